// File: rtl/ram_cb_multilane.sv
// Circular sample buffer: each read returns LANES consecutive-age samples, rotated into lane order.
// Optional macro CB_ZERO_FILL_EN zeroes lanes whose age is not yet covered by the fill level.
module ram_cb_multilane #(
  parameter int DATA_W = 18,
  parameter int LANES  = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = ADDR_W + $clog2(LANES) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       xin,
  input  logic                    enxk,
  input  logic [ADDR_W-1:0]       addrin,
  input  logic                    rden,
  output logic [LANES*DATA_W-1:0] rdout,
  output logic                    rdvalid,
  output logic [CNT_W-1:0]        fill,
  output logic                    full
);
  localparam int LB   = $clog2(LANES);
  localparam int PW   = ADDR_W + LB;
  localparam int ROWS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LANES * ROWS);

  // stage 1: input register
  logic [DATA_W-1:0] xin_reg;
  logic              enxk_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rden_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      xin_reg  <= '0;
      enxk_reg <= 1'b0;
      addr_reg <= '0;
      rden_reg <= 1'b0;
    end else begin
      xin_reg  <= xin;
      enxk_reg <= enxk;
      addr_reg <= addrin;
      rden_reg <= rden;
    end
  end

  // stage 2: write pointer, fill level and per-bank read addressing
  logic [PW-1:0]     wp_reg;
  logic [CNT_W-1:0]  fill_reg;
  logic              full_reg;
  logic [PW-1:0]     base;
  logic [LB-1:0]     rot;
  logic [ADDR_W-1:0] base_row;

  // base is the position of lane 0's sample; the read uses wp before this cycle's write
  assign base     = wp_reg - PW'(1) - {addr_reg, {LB{1'b0}}};
  assign rot      = base[LB-1:0];
  assign base_row = base[PW-1:LB];

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_reg   <= '0;
      fill_reg <= '0;
      full_reg <= 1'b0;
    end else if (enxk_reg) begin
      wp_reg <= wp_reg + PW'(1);
      if (fill_reg != DEPTH_C)
        fill_reg <= fill_reg + CNT_W'(1);
      if (fill_reg == DEPTH_C - CNT_W'(1))
        full_reg <= 1'b1;
    end
  end

  logic [DATA_W-1:0]       ram_q_w   [LANES];
  logic [DATA_W-1:0]       ram_p_reg [LANES];
  logic [LANES*DATA_W-1:0] rot_word;
  logic [LB-1:0]           rot2_reg, rot3_reg;
`ifdef CB_ZERO_FILL_EN
  logic [LANES-1:0]        zmask, zmask2_reg, zmask3_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gen_bank
      localparam logic [LB-1:0] BANK = LB'(gi);
      logic [DATA_W-1:0] mem [ROWS];
      logic [DATA_W-1:0] bank_q;
      logic [ADDR_W-1:0] rd_row;
      logic [LB-1:0]     src;

      // banks above the phase hold samples one row further back
      assign rd_row = base_row - ADDR_W'(BANK > rot);

      always_ff @(posedge clock) begin
        if (enxk_reg && wp_reg[LB-1:0] == BANK)
          mem[wp_reg[PW-1:LB]] <= xin_reg;
        if (rden_reg)
          bank_q <= mem[rd_row];
      end
      assign ram_q_w[gi] = bank_q;

      // lane gi comes from bank (phase - gi) mod LANES
      assign src = rot3_reg - BANK;
`ifdef CB_ZERO_FILL_EN
      assign zmask[gi] = {1'b0, addr_reg, BANK} >= fill_reg;
      assign rot_word[gi*DATA_W +: DATA_W] = zmask3_reg[gi] ? '0 : ram_p_reg[src];
`else
      assign rot_word[gi*DATA_W +: DATA_W] = ram_p_reg[src];
`endif
    end
  endgenerate

  // stage 3: bank-output register, then rotate into the output register
  logic                    valid2_reg, valid3_reg, rdvalid_reg;
  logic [LANES*DATA_W-1:0] rdout_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid2_reg  <= 1'b0;
      valid3_reg  <= 1'b0;
      rdvalid_reg <= 1'b0;
      rdout_reg   <= '0;
    end else begin
      valid2_reg  <= rden_reg;
      rot2_reg    <= rot;
      valid3_reg  <= valid2_reg;
      rot3_reg    <= rot2_reg;
      ram_p_reg   <= ram_q_w;
`ifdef CB_ZERO_FILL_EN
      zmask2_reg  <= zmask;
      zmask3_reg  <= zmask2_reg;
`endif
      rdvalid_reg <= valid3_reg;
      if (valid3_reg)
        rdout_reg <= rot_word;
    end
  end

  assign rdout   = rdout_reg;
  assign rdvalid = rdvalid_reg;
  assign fill    = fill_reg;
  assign full    = full_reg;
endmodule

// File: tb/tb_ram_cb_multilane.sv
// Scoreboard bench driving a LANES=8/ADDR_W=11 and a LANES=4/ADDR_W=2 buffer with shared stimulus.
module tb_ram_cb_multilane;
  localparam int DW = 18;
  localparam int BL = 8;
  localparam int BA = 11;
  localparam int SL = 4;
  localparam int SA = 2;
  localparam int WW = 16 * DW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, enxk, rden;
  logic [DW-1:0] xin;
  logic [BA-1:0] addrin;

  logic [BL*DW-1:0] rdout_b;
  logic             rdvalid_b, full_b;
  logic [BA+3:0]    fill_b;
  logic [SL*DW-1:0] rdout_s;
  logic             rdvalid_s, full_s;
  logic [SA+2:0]    fill_s;

  ram_cb_multilane #(.DATA_W(DW), .LANES(BL), .ADDR_W(BA)) u_big (
    .clock(clock), .reset(reset), .xin(xin), .enxk(enxk), .addrin(addrin), .rden(rden),
    .rdout(rdout_b), .rdvalid(rdvalid_b), .fill(fill_b), .full(full_b)
  );

  ram_cb_multilane #(.DATA_W(DW), .LANES(SL), .ADDR_W(SA)) u_small (
    .clock(clock), .reset(reset), .xin(xin), .enxk(enxk), .addrin(addrin[SA-1:0]), .rden(rden),
    .rdout(rdout_s), .rdvalid(rdvalid_s), .fill(fill_s), .full(full_s)
  );

  typedef struct {
    logic [WW-1:0] data;
    logic [WW-1:0] mask;
  } exp_t;

  exp_t          qb[$];
  exp_t          qs[$];
  logic [DW-1:0] hist[$];
  int            checks = 0;
  int            errors = 0;

  // Expected lanes: age k is the k-th newest write; ages not yet written are unchecked
  // unless zero fill is built in, in which case they must read as 0.
  function automatic exp_t model(input int lanes, input int aw, input int a_full);
    exp_t e;
    int a, depth, avail, k;
    e.data = '0;
    e.mask = '0;
    a      = a_full % (1 << aw);
    depth  = lanes << aw;
    avail  = (hist.size() < depth) ? hist.size() : depth;
    for (int j = 0; j < lanes; j++) begin
      k = a * lanes + j;
      if (k < avail) begin
        e.data[j*DW +: DW] = hist[hist.size()-1-k];
        e.mask[j*DW +: DW] = '1;
      end
`ifdef CB_ZERO_FILL_EN
      else e.mask[j*DW +: DW] = '1;
`endif
    end
    return e;
  endfunction

  task automatic step(input logic we, input int x, input logic re, input int a);
    @(negedge clock);
    if (re) begin
      qb.push_back(model(BL, BA, a));
      qs.push_back(model(SL, SA, a));
    end
    enxk   = we;
    xin    = DW'(x);
    rden   = re;
    addrin = BA'(a);
    if (we) hist.push_back(DW'(x));
    if (we || re) $display("drive enxk=%0b xin=%0d rden=%0b addrin=%0d", we, x, re, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  exp_t          eb, es;
  logic [WW-1:0] ob, os;

  always @(negedge clock) begin
    if (rdvalid_b) begin
      checks++;
      assert (qb.size() != 0) else begin
        errors++;
        $error("FAIL big_unexpected_rdvalid observed=1 expected=0");
      end
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        ob = '0;
        ob[BL*DW-1:0] = rdout_b;
        ob = ob & eb.mask;
        $display("big   read rdout=%h", rdout_b);
        checks++;
        assert (ob === eb.data) else begin
          errors++;
          $error("FAIL big_rdout observed=%h expected=%h", ob, eb.data);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (rdvalid_s) begin
      checks++;
      assert (qs.size() != 0) else begin
        errors++;
        $error("FAIL small_unexpected_rdvalid observed=1 expected=0");
      end
      if (qs.size() != 0) begin
        es = qs.pop_front();
        os = '0;
        os[SL*DW-1:0] = rdout_s;
        os = os & es.mask;
        $display("small read rdout=%h", rdout_s);
        checks++;
        assert (os === es.data) else begin
          errors++;
          $error("FAIL small_rdout observed=%h expected=%h", os, es.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enxk = 1'b0; rden = 1'b0; xin = '0; addrin = '0;
    repeat (2) @(negedge clock);
    chk("big_reset_rdout", WW'(rdout_b), '0);
    chk("big_reset_rdvalid", WW'(rdvalid_b), '0);
    chk("big_reset_fill", WW'(fill_b), '0);
    chk("big_reset_full", WW'(full_b), '0);
    chk("small_reset_rdout", WW'(rdout_s), '0);
    chk("small_reset_rdvalid", WW'(rdvalid_s), '0);
    chk("small_reset_fill", WW'(fill_s), '0);
    chk("small_reset_full", WW'(full_s), '0);
    reset = 1'b0;
    hist.delete();

    // fill to one below the small buffer's depth, then complete it
    for (int i = 1; i <= 15; i++) step(1'b1, i, 1'b0, 0);
    idle(3);
    chk("small_fill_15", WW'(fill_s), WW'(15));
    chk("small_full_at_15", WW'(full_s), WW'(0));
    step(1'b1, 16, 1'b0, 0);
    idle(3);
    chk("small_fill_16", WW'(fill_s), WW'(16));
    chk("small_full_at_16", WW'(full_s), WW'(1));
    chk("big_fill_16", WW'(fill_b), WW'(16));
    chk("big_full_at_16", WW'(full_b), WW'(0));

    // aligned reads, isolated and back-to-back
    step(1'b0, 0, 1'b1, 0);
    idle(4);
    step(1'b0, 0, 1'b1, 1);
    step(1'b0, 0, 1'b1, 0);
    step(1'b0, 0, 1'b1, 1);
    idle(5);

    // misaligned phase, then wrap in the small buffer
    for (int i = 17; i <= 19; i++) step(1'b1, i, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0);
    step(1'b1, 20, 1'b0, 0);
    idle(3);
    chk("small_fill_sat", WW'(fill_s), WW'(16));
    chk("small_full_sat", WW'(full_s), WW'(1));
    chk("big_fill_20", WW'(fill_b), WW'(20));
    for (int a = 0; a < 4; a++) step(1'b0, 0, 1'b1, a);
    idle(5);

    // same-cycle read and write
    @(negedge clock); reset = 1'b1; enxk = 1'b0; rden = 1'b0;
    @(negedge clock); reset = 1'b0;
    hist.delete();
    chk("big_fill_after_reset", WW'(fill_b), '0);
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 0);
    step(1'b1, 9, 1'b1, 0);
    step(1'b0, 0, 1'b1, 0);
    idle(5);

    // reset while a read is in flight discards it
    step(1'b0, 0, 1'b1, 0);
    @(negedge clock); reset = 1'b1; rden = 1'b0;
    qb.delete(); qs.delete(); hist.delete();
    @(negedge clock); reset = 1'b0;
    idle(6);
    chk("big_fill_midreset", WW'(fill_b), '0);
    chk("big_full_midreset", WW'(full_b), '0);
    chk("small_fill_midreset", WW'(fill_s), '0);
    chk("small_full_midreset", WW'(full_s), '0);

    // partially filled buffer
    step(1'b1, 5, 1'b0, 0);
    step(1'b1, 6, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0);
    idle(6);

    for (int i = 0; i < 20 && (qb.size() != 0 || qs.size() != 0); i++) @(negedge clock);
    chk("big_pending_reads", WW'(qb.size()), '0);
    chk("small_pending_reads", WW'(qs.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
